// File: rtl/spi_frame_slave_if.sv
// ---------------------------------------------------------------------------
// spi_frame_slave_if
//   Bundles the SPI pins and the frame data/status bus of spi_frame_slave.
//   BUFFER_SIZE must match the value given to the slave.
//   slave modport  : SPI pins and tx_data in; MISO, rx_data and status out.
//   master modport : the mirror image, used by the SPI master / firmware side.
// ---------------------------------------------------------------------------
interface spi_frame_slave_if #(
    parameter int BUFFER_SIZE = 64
);
    logic                   SPI_SCK;
    logic                   SPI_SSEL;
    logic                   SPI_MOSI;
    logic                   SPI_MISO;
    logic [BUFFER_SIZE-1:0] tx_data;
    logic [BUFFER_SIZE-1:0] rx_data;
    logic                   rx_valid;
    logic                   busy;
    logic [7:0]             frame_err_count;
    logic                   pkg_timeout;

    modport slave (
        input  SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
        output SPI_MISO, rx_data, rx_valid, busy, frame_err_count, pkg_timeout
    );

    modport master (
        output SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
        input  SPI_MISO, rx_data, rx_valid, busy, frame_err_count, pkg_timeout
    );
endinterface

// File: rtl/spi_frame_slave.sv
// ---------------------------------------------------------------------------
// spi_frame_slave
//   SPI slave that exchanges one fixed-length frame per chip-select window.
//   SCK/SSEL/MOSI are oversampled in the clk domain. A frame is accepted only
//   if exactly BUFFER_SIZE bits arrived and the top 32 bits equal MSGID;
//   anything else bumps a saturating error counter. Mode set by CPOL/CPHA.
//
//   Optional feature macro: SPI_CRC8_EN
//     When defined, the last 8 bits of each frame are a CRC-8 (poly 0x07,
//     init 0) over the preceding bits: checked on receive, generated on
//     transmit in place of tx_data[7:0].
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : spi_frame_slave_if.slave
//       SPI_SCK/SPI_SSEL/SPI_MOSI in, SPI_MISO out (MSB first)
//       tx_data in (captured at frame start), rx_data out (last good frame)
//       rx_valid one-cycle strobe, busy, frame_err_count, pkg_timeout
// ---------------------------------------------------------------------------
module spi_frame_slave #(
    parameter int          BUFFER_SIZE = 64,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          TIMEOUT     = 4800000,
    parameter int          CPOL        = 0,
    parameter int          CPHA        = 0
) (
    input  logic              clk,
    input  logic              reset,
    spi_frame_slave_if.slave  bus
);
    localparam int             B       = BUFFER_SIZE;
    localparam int             CW      = $clog2(BUFFER_SIZE + 2);
    localparam logic [CW-1:0]  BC_FULL = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0]  BC_SAT  = CW'(BUFFER_SIZE + 1);
    localparam logic [31:0]    TMO     = 32'(TIMEOUT);
    localparam logic [2:0]     SCK_RST = (CPOL != 0) ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    // ---------------- synchronisers and edge detect ----------------
    logic [2:0] sck_q, ssel_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q  <= SCK_RST;
            ssel_q <= 3'b111;   // preset idle so a low SSEL after reset is a start
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], bus.SPI_SCK};
            ssel_q <= {ssel_q[1:0], bus.SPI_SSEL};
            mosi_q <= {mosi_q[0], bus.SPI_MOSI};
        end
    end

    logic sck_rise, sck_fall, lead_e, trail_e, sample_e, launch_e;
    logic ssel_fall, ssel_rise, mosi_s;

    assign sck_rise  =  sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] &  sck_q[2];
    assign lead_e    = (CPOL != 0) ? sck_fall : sck_rise;
    assign trail_e   = (CPOL != 0) ? sck_rise : sck_fall;
    assign sample_e  = (CPHA != 0) ? trail_e  : lead_e;
    assign launch_e  = (CPHA != 0) ? lead_e   : trail_e;
    assign ssel_fall =  ssel_q[2] & ~ssel_q[1];
    assign ssel_rise = ~ssel_q[2] &  ssel_q[1];
    assign mosi_s    = mosi_q[1];   // same age as sck_q[1]

`ifdef SPI_CRC8_EN
    localparam logic [CW-1:0] PAY_CNT  = CW'(BUFFER_SIZE - 8);
    localparam logic [CW-1:0] PAY_LAST = CW'(BUFFER_SIZE - 9);

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // ---------------- frame state machine ----------------
    state_t         state_q, state_d;
    logic [CW-1:0]  bitcnt_q, bitcnt_d;
    logic [B-1:0]   txsr_q, txsr_d;
    logic [B-1:0]   rxsr_q, rxsr_d;
    logic           first_q, first_d;
    logic           accept, reject, crc_ok;
`ifdef SPI_CRC8_EN
    logic [7:0]     rxcrc_q, rxcrc_d, txcrc_q, txcrc_d, crc_nxt;
    logic [CW-1:0]  txcnt_q, txcnt_d;

    // CRC run over payload plus trailer leaves a zero residue when intact.
    assign crc_ok = (rxcrc_q == 8'h00);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        txsr_d   = txsr_q;
        rxsr_d   = rxsr_q;
        first_d  = first_q;
        accept   = 1'b0;
        reject   = 1'b0;
`ifdef SPI_CRC8_EN
        rxcrc_d  = rxcrc_q;
        txcrc_d  = txcrc_q;
        txcnt_d  = txcnt_q;
        crc_nxt  = 8'h00;
`endif
        unique case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    txsr_d   = bus.tx_data;
                    bitcnt_d = '0;
                    first_d  = 1'b1;
                    state_d  = SHIFT;
`ifdef SPI_CRC8_EN
                    rxcrc_d  = 8'h00;
                    txcrc_d  = 8'h00;
                    txcnt_d  = '0;
`endif
                end
            end
            SHIFT: begin
                // SSEL release wins; a coincident SCK edge is dropped.
                if (ssel_rise) begin
                    state_d = CHECK;
                end else if (sample_e) begin
                    rxsr_d = {rxsr_q[B-2:0], mosi_s};
                    if (bitcnt_q != BC_SAT)
                        bitcnt_d = bitcnt_q + 1'b1;
`ifdef SPI_CRC8_EN
                    if (bitcnt_q < BC_FULL)
                        rxcrc_d = crc8_step(rxcrc_q, mosi_s);
`endif
                end else if (launch_e) begin
                    // In CPHA=1 the first bit is already on MISO before the
                    // first leading edge, so that edge must not shift.
                    if ((CPHA != 0) && first_q) begin
                        first_d = 1'b0;
                    end else begin
                        txsr_d = {txsr_q[B-2:0], 1'b0};
`ifdef SPI_CRC8_EN
                        if (txcnt_q < PAY_CNT) begin
                            crc_nxt = crc8_step(txcrc_q, txsr_q[B-1]);
                            txcrc_d = crc_nxt;
                            // last payload bit leaving: trailer goes out next
                            if (txcnt_q == PAY_LAST)
                                txsr_d = {crc_nxt, {(B-8){1'b0}}};
                        end
                        if (txcnt_q != BC_SAT)
                            txcnt_d = txcnt_q + 1'b1;
`endif
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (bitcnt_q != '0) begin
                    if (bitcnt_q == BC_FULL && rxsr_q[B-1 -: 32] == MSGID && crc_ok)
                        accept = 1'b1;
                    else
                        reject = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            txsr_q   <= '0;
            rxsr_q   <= '0;
            first_q  <= 1'b0;
`ifdef SPI_CRC8_EN
            rxcrc_q  <= 8'h00;
            txcrc_q  <= 8'h00;
            txcnt_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            txsr_q   <= txsr_d;
            rxsr_q   <= rxsr_d;
            first_q  <= first_d;
`ifdef SPI_CRC8_EN
            rxcrc_q  <= rxcrc_d;
            txcrc_q  <= txcrc_d;
            txcnt_q  <= txcnt_d;
`endif
        end
    end

    // ---------------- outputs / status ----------------
    logic [B-1:0] rx_data_q;
    logic         rx_valid_q, busy_q, pkg_q;
    logic [7:0]   err_q;
    logic [31:0]  tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            pkg_q      <= 1'b0;
            err_q      <= 8'h00;
            tmo_q      <= '0;
        end else begin
            rx_valid_q <= accept;
            busy_q     <= ~ssel_q[2];
            pkg_q      <= (tmo_q >= TMO);
            if (accept)
                rx_data_q <= rxsr_q;
            if (reject && err_q != 8'hFF)
                err_q <= err_q + 8'h01;
            if (accept)
                tmo_q <= '0;
            else if (tmo_q < TMO)
                tmo_q <= tmo_q + 32'd1;
        end
    end

    assign bus.SPI_MISO        = (state_q == SHIFT) && (bitcnt_q < BC_FULL) && txsr_q[B-1];
    assign bus.rx_data         = rx_data_q;
    assign bus.rx_valid        = rx_valid_q;
    assign bus.busy            = busy_q;
    assign bus.frame_err_count = err_q;
    assign bus.pkg_timeout     = pkg_q;
endmodule

// File: tb/tb_spi_frame_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_slave
//   Four slaves, one per SPI mode (index = {CPOL,CPHA}), share SSEL, MOSI and
//   tx_data; each gets SCK at its own idle polarity. MOSI changes in the
//   middle of the idle phase so it is stable across both edges of a bit,
//   which lets a single MOSI stream serve every mode.
// ---------------------------------------------------------------------------
module tb_spi_frame_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sck_base = 1'b0;
    logic        ssel = 1'b1;
    logic        mosi = 1'b0;
    logic [63:0] tx_data = 64'h0123456789ABCDEF;

    logic [3:0]        miso_w, vld_w, busy_w, pkg_w;
    logic [3:0][63:0]  rxd_w;
    logic [3:0][7:0]   err_w;
    logic [3:0][127:0] miso_cap;
    int                vcnt [4];
    int                checks = 0;
    int                fails  = 0;

    for (genvar g = 0; g < 4; g++) begin : m
        localparam int CP = g / 2;
        localparam int CH = g % 2;
        spi_frame_slave_if #(.BUFFER_SIZE(64)) bus ();
        assign bus.SPI_SCK  = sck_base ^ (CP != 0);
        assign bus.SPI_SSEL = ssel;
        assign bus.SPI_MOSI = mosi;
        assign bus.tx_data  = tx_data;
        assign miso_w[g] = bus.SPI_MISO;
        assign vld_w[g]  = bus.rx_valid;
        assign busy_w[g] = bus.busy;
        assign pkg_w[g]  = bus.pkg_timeout;
        assign rxd_w[g]  = bus.rx_data;
        assign err_w[g]  = bus.frame_err_count;
        spi_frame_slave #(
            .BUFFER_SIZE(64), .MSGID(32'h74697277), .TIMEOUT(100),
            .CPOL(CP), .CPHA(CH)
        ) u_dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
    end

    // Counts cycles with rx_valid high, so a wide pulse shows up as >1.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) vcnt[i] = 0;
            else if (vld_w[i]) vcnt[i] = vcnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef SPI_CRC8_EN
    function automatic logic [7:0] crc8(input logic [55:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 55; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [63:0] fix_crc(input logic [63:0] f);
        return {f[63:8], crc8(f[63:8])};
    endfunction
`else
    function automatic logic [63:0] fix_crc(input logic [63:0] f);
        return f;
    endfunction
`endif

    // Clocks n bits of f (MSB first) and records MISO at each mode's sample edge.
    task automatic send_bits(input logic [127:0] f, input int n);
        wclk(10);
        for (int i = 0; i < n; i++) begin
            mosi = f[n-1-i];
            wclk(4);
            for (int k = 0; k < 4; k += 2) miso_cap[k] = {miso_cap[k][126:0], miso_w[k]};
            sck_base = 1'b1;
            wclk(8);
            for (int k = 1; k < 4; k += 2) miso_cap[k] = {miso_cap[k][126:0], miso_w[k]};
            sck_base = 1'b0;
            wclk(4);
        end
    endtask

    task automatic start_frame();
        miso_cap = '0;
        ssel = 1'b0;
    endtask

    task automatic end_frame();
        wclk(4);
        ssel = 1'b1;
        wclk(12);
    endtask

    task automatic frame(input logic [127:0] f, input int n);
        start_frame();
        send_bits(f, n);
        end_frame();
    endtask

    logic [63:0] good, exp_miso, crc_frame, crc_bad;

    initial begin
        good     = fix_crc(64'h74697277DEADBEEF);
        exp_miso = fix_crc(64'h0123456789ABCDEF);

        // reset values
        wclk(3);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst rx_data m%0d", g), rxd_w[g], 0);
            chk($sformatf("rst rx_valid m%0d", g), vld_w[g], 0);
            chk($sformatf("rst busy m%0d", g), busy_w[g], 0);
            chk($sformatf("rst err m%0d", g), err_w[g], 0);
            chk($sformatf("rst pkg m%0d", g), pkg_w[g], 0);
            chk($sformatf("rst miso m%0d", g), miso_w[g], 0);
        end
        reset = 1'b0;

        // timeout with no frames (TIMEOUT=100)
        wclk(95);
        chk("tmo early", pkg_w[0], 0);
        wclk(10);
        chk("tmo set", pkg_w[0], 1);

        // well-formed frame, all four modes
        start_frame();
        send_bits({64'h0, good}, 64);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("busy mid m%0d", g), busy_w[g], 1);
            chk($sformatf("tmo before m%0d", g), pkg_w[g], 1);
        end
        end_frame();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("good rx_data m%0d", g), rxd_w[g], good);
            chk($sformatf("good pulses m%0d", g), vcnt[g], 1);
            chk($sformatf("good miso m%0d", g), miso_cap[g][63:0], exp_miso);
            chk($sformatf("good err m%0d", g), err_w[g], 0);
            chk($sformatf("good tmo clr m%0d", g), pkg_w[g], 0);
            chk($sformatf("busy idle m%0d", g), busy_w[g], 0);
        end

        // bad frames: short, long, wrong header
        frame({65'h0, good[63:1]}, 63);
        frame({63'h0, good, 1'b0}, 65);
        frame({64'h0, 64'h74697377DEADBEEF}, 64);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("bad pulses m%0d", g), vcnt[g], 1);
            chk($sformatf("bad rx_data m%0d", g), rxd_w[g], good);
            chk($sformatf("bad err m%0d", g), err_w[g], 3);
        end

        // error counter saturation
        for (int i = 0; i < 300; i++) frame(128'h1, 1);
        for (int g = 0; g < 4; g++)
            chk($sformatf("err sat m%0d", g), err_w[g], 255);

        // reset mid-frame, SSEL held low through release
        start_frame();
        send_bits({64'h0, good}, 20);
        reset = 1'b1;
        wclk(2);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("mid rst rx_data m%0d", g), rxd_w[g], 0);
            chk($sformatf("mid rst err m%0d", g), err_w[g], 0);
            chk($sformatf("mid rst busy m%0d", g), busy_w[g], 0);
            chk($sformatf("mid rst miso m%0d", g), miso_w[g], 0);
            chk($sformatf("mid rst vld m%0d", g), vld_w[g], 0);
            chk($sformatf("mid rst pkg m%0d", g), pkg_w[g], 0);
        end
        reset = 1'b0;
        send_bits({84'h0, good[43:0]}, 44);
        end_frame();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("trunc err m%0d", g), err_w[g], 1);
            chk($sformatf("trunc pulses m%0d", g), vcnt[g], 0);
            chk($sformatf("trunc rx_data m%0d", g), rxd_w[g], 0);
        end

`ifdef SPI_CRC8_EN
        crc_frame = fix_crc(64'h74697277CAFEF000);
        crc_bad   = crc_frame ^ 64'h10;
        frame({64'h0, crc_frame}, 64);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("crc ok rx m%0d", g), rxd_w[g], crc_frame);
            chk($sformatf("crc ok err m%0d", g), err_w[g], 1);
            chk($sformatf("crc tx trailer m%0d", g), miso_cap[g][7:0], crc8(tx_data[63:8]));
        end
        frame({64'h0, crc_bad}, 64);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("crc bad rx m%0d", g), rxd_w[g], crc_frame);
            chk($sformatf("crc bad err m%0d", g), err_w[g], 2);
        end
`else
        crc_frame = '0;
        crc_bad   = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
